// File: rtl/morse_decoder.sv
// Morse key receiver: times a synchronized key line, builds up to five dot/dash
// elements per character and decodes them on an inter-letter gap.
module morse_decoder #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_PRESS  = 2,
  parameter int unsigned DOT_MAX    = 10,
  parameter int unsigned LETTER_GAP = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [4:0] morse_code,
  output logic [2:0] morse_len,
  output logic [5:0] char_code,
  output logic       char_valid,
  output logic       char_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_EMIT,
    S_OVF
  } state_t;

  localparam logic [5:0]       CODE_NONE = 6'd63;
  localparam logic [CNT_W-1:0] C_MIN     = CNT_W'(MIN_PRESS);
  localparam logic [CNT_W-1:0] C_DOT     = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] C_GAP     = CNT_W'(LETTER_GAP);

  logic             r_sync1;
  logic             r_key_s;
  logic [CNT_W-1:0] r_press_cnt;
  logic [CNT_W-1:0] r_gap_cnt;
  state_t           r_state;
  logic [4:0]       r_elems;
  logic [2:0]       r_nelem;
  logic [4:0]       r_morse_code;
  logic [2:0]       r_morse_len;
  logic [5:0]       r_char_code;
  logic             r_char_valid;
  logic             r_char_err;
  logic             r_busy;

  logic [CNT_W-1:0] w_press_inc;
  logic [CNT_W-1:0] w_gap_inc;
  logic             w_gap_done;
  logic             w_glitch;
  logic             w_dash;
  logic             w_dec_ok;
  logic [5:0]       w_dec_code;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_key_s <= 1'b0;
    end else begin
      r_sync1 <= key_in;
      r_key_s <= r_sync1;
    end
  end

  assign w_press_inc = (r_press_cnt == '1) ? r_press_cnt : r_press_cnt + CNT_W'(1);
  assign w_gap_inc   = (r_gap_cnt == '1)   ? r_gap_cnt   : r_gap_cnt + CNT_W'(1);

  // The gap counter runs in every state, so the low cycle that classifies the
  // last press already counts toward the letter gap.
  assign w_gap_done = !r_key_s && (w_gap_inc == C_GAP);
  assign w_glitch   = (r_press_cnt < C_MIN);
  assign w_dash     = (r_press_cnt > C_DOT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_press_cnt <= '0;
      r_gap_cnt   <= '0;
    end else if (r_key_s) begin
      r_press_cnt <= w_press_inc;
      r_gap_cnt   <= '0;
    end else begin
      r_press_cnt <= '0;
      r_gap_cnt   <= w_gap_inc;
    end
  end

  // Element 0 sits in bit 0; unused high bits are always zero, so the
  // length/pattern pair is a unique key into the International Morse table.
  always_comb begin
    w_dec_ok   = 1'b1;
    w_dec_code = CODE_NONE;
    case ({r_nelem, r_elems})
      {3'd1, 5'b00000}: w_dec_code = 6'd14;
      {3'd1, 5'b00001}: w_dec_code = 6'd29;
      {3'd2, 5'b00010}: w_dec_code = 6'd10;
      {3'd2, 5'b00000}: w_dec_code = 6'd18;
      {3'd2, 5'b00011}: w_dec_code = 6'd22;
      {3'd2, 5'b00001}: w_dec_code = 6'd23;
      {3'd3, 5'b00001}: w_dec_code = 6'd13;
      {3'd3, 5'b00011}: w_dec_code = 6'd16;
      {3'd3, 5'b00101}: w_dec_code = 6'd20;
      {3'd3, 5'b00111}: w_dec_code = 6'd24;
      {3'd3, 5'b00010}: w_dec_code = 6'd27;
      {3'd3, 5'b00000}: w_dec_code = 6'd28;
      {3'd3, 5'b00100}: w_dec_code = 6'd30;
      {3'd3, 5'b00110}: w_dec_code = 6'd32;
      {3'd4, 5'b00001}: w_dec_code = 6'd11;
      {3'd4, 5'b00101}: w_dec_code = 6'd12;
      {3'd4, 5'b00100}: w_dec_code = 6'd15;
      {3'd4, 5'b00000}: w_dec_code = 6'd17;
      {3'd4, 5'b01110}: w_dec_code = 6'd19;
      {3'd4, 5'b00010}: w_dec_code = 6'd21;
      {3'd4, 5'b00110}: w_dec_code = 6'd25;
      {3'd4, 5'b01011}: w_dec_code = 6'd26;
      {3'd4, 5'b01000}: w_dec_code = 6'd31;
      {3'd4, 5'b01001}: w_dec_code = 6'd33;
      {3'd4, 5'b01101}: w_dec_code = 6'd34;
      {3'd4, 5'b00011}: w_dec_code = 6'd35;
      {3'd5, 5'b11111}: w_dec_code = 6'd0;
      {3'd5, 5'b11110}: w_dec_code = 6'd1;
      {3'd5, 5'b11100}: w_dec_code = 6'd2;
      {3'd5, 5'b11000}: w_dec_code = 6'd3;
      {3'd5, 5'b10000}: w_dec_code = 6'd4;
      {3'd5, 5'b00000}: w_dec_code = 6'd5;
      {3'd5, 5'b00001}: w_dec_code = 6'd6;
      {3'd5, 5'b00011}: w_dec_code = 6'd7;
      {3'd5, 5'b00111}: w_dec_code = 6'd8;
      {3'd5, 5'b01111}: w_dec_code = 6'd9;
      default:          w_dec_ok   = 1'b0;
    endcase
  end

  // Pulses are registered on the same edge that enters EMIT, so they appear
  // in the cycle right after the final gap cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_elems      <= '0;
      r_nelem      <= '0;
      r_morse_code <= '0;
      r_morse_len  <= '0;
      r_char_code  <= CODE_NONE;
      r_char_valid <= 1'b0;
      r_char_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_char_valid <= 1'b0;
      r_char_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_key_s) begin
            r_state <= S_PRESS;
            r_busy  <= 1'b1;
          end
        end
        S_PRESS: begin
          if (!r_key_s) begin
            if (w_glitch) begin
              if (r_nelem != 3'd0) begin
                r_state <= S_GAP;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else if (r_nelem == 3'd5) begin
              r_state <= S_OVF;
            end else begin
              r_elems <= r_elems | (5'(w_dash) << r_nelem);
              r_nelem <= r_nelem + 3'd1;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_key_s) begin
            r_state <= S_PRESS;
          end else if (w_gap_done) begin
            r_morse_code <= r_elems;
            r_morse_len  <= r_nelem;
            r_char_valid <= w_dec_ok;
            r_char_err   <= !w_dec_ok;
            r_char_code  <= w_dec_ok ? w_dec_code : CODE_NONE;
            r_state      <= S_EMIT;
          end
        end
        S_EMIT: begin
          r_elems <= '0;
          r_nelem <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_OVF: begin
          if (w_gap_done) begin
            r_char_err  <= 1'b1;
            r_char_code <= CODE_NONE;
            r_elems     <= '0;
            r_nelem     <= '0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_elems <= '0;
          r_nelem <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign morse_code = r_morse_code;
  assign morse_len  = r_morse_len;
  assign char_code  = r_char_code;
  assign char_valid = r_char_valid;
  assign char_err   = r_char_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: directed plus random key sequences checked against a
// string-based model of the press classification and International Morse table.
module tb_morse_decoder;

  localparam int MIN_PRESS  = 2;
  localparam int DOT_MAX    = 10;
  localparam int LETTER_GAP = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_in = 1'b0;
  logic [4:0] morse_code;
  logic [2:0] morse_len;
  logic [5:0] char_code;
  logic       char_valid;
  logic       char_err;
  logic       busy;

  morse_decoder #(
    .CNT_W(16),
    .MIN_PRESS(MIN_PRESS),
    .DOT_MAX(DOT_MAX),
    .LETTER_GAP(LETTER_GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .morse_code(morse_code),
    .morse_len(morse_len),
    .char_code(char_code),
    .char_valid(char_valid),
    .char_err(char_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  string pats[36] = '{"-----", ".----", "..---", "...--", "....-", ".....",
                      "-....", "--...", "---..", "----.",
                      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                      "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                      "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                      "-.--", "--.."};

  int         cyc = 0;
  int         ev_n = 0;
  int         ev_cyc = 0;
  logic       ev_v, ev_e;
  logic [5:0] ev_code;
  logic [4:0] ev_mc;
  logic [2:0] ev_ml;
  int         both_cnt = 0;

  int         n_tests = 0;
  int         n_fail = 0;
  int         pl[$];
  int         gl[$];
  int         fall_cyc = 0;
  logic [5:0] last_code = 6'd63;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (char_valid || char_err) begin
      ev_n    <= ev_n + 1;
      ev_cyc  <= cyc;
      ev_v    <= char_valid;
      ev_e    <= char_err;
      ev_code <= char_code;
      ev_mc   <= morse_code;
      ev_ml   <= morse_len;
    end
    if (char_valid && char_err) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    key_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic play();
    for (int i = 0; i < pl.size(); i++) begin
      hold(1'b1, pl[i]);
      if (i < pl.size() - 1) hold(1'b0, gl[i]);
    end
    key_in   = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic model(output bit pulse, output bit v, output bit e, output bit ovf,
                       output logic [5:0] code, output logic [4:0] mc,
                       output logic [2:0] ml);
    string s;
    int    idx;
    s   = "";
    ovf = 1'b0;
    foreach (pl[i]) begin
      if (pl[i] >= MIN_PRESS) begin
        if (s.len() == 5) ovf = 1'b1;
        else if (!ovf && pl[i] <= DOT_MAX) s = {s, "."};
        else if (!ovf) s = {s, "-"};
      end
    end
    pulse = (s.len() > 0);
    idx   = -1;
    for (int k = 0; k < 36; k++) if (pats[k] == s) idx = k;
    v    = pulse && !ovf && (idx >= 0);
    e    = pulse && !v;
    code = v ? 6'(idx) : 6'd63;
    mc   = '0;
    for (int j = 0; j < s.len(); j++) if (s[j] == 8'h2D) mc[j] = 1'b1;
    ml   = 3'(s.len());
  endtask

  task automatic evaluate(input int e0);
    bit         pulse, v, e, ovf;
    logic [5:0] code;
    logic [4:0] mc;
    logic [2:0] ml;
    model(pulse, v, e, ovf, code, mc, ml);
    hold(1'b0, 5);
    chk("busy_gap", busy, pulse);
    hold(1'b0, LETTER_GAP + 2);
    chk("pulse_count", ev_n - e0, pulse);
    if (pulse) begin
      chk("char_valid", ev_v, v);
      chk("char_err", ev_e, e);
      chk("char_code", ev_code, code);
      chk("emit_delay", ev_cyc - fall_cyc, LETTER_GAP + 2);
      if (!ovf) begin
        chk("morse_code", ev_mc, mc);
        chk("morse_len", ev_ml, ml);
      end
      last_code = code;
    end else begin
      chk("busy_idle", busy, 0);
      chk("code_hold", char_code, last_code);
    end
  endtask

  task automatic run_char();
    int e0;
    e0 = ev_n;
    play();
    evaluate(e0);
  endtask

  task automatic gen_random();
    int    kind, n, a;
    string s;
    pl.delete();
    gl.delete();
    kind = $urandom_range(0, 9);
    if (kind < 7) begin
      s = pats[$urandom_range(0, 35)];
      for (int i = 0; i < s.len(); i++) begin
        if (s[i] == 8'h2E) pl.push_back($urandom_range(MIN_PRESS, DOT_MAX));
        else pl.push_back($urandom_range(DOT_MAX + 1, DOT_MAX + 30));
        if (i < s.len() - 1) begin
          if ($urandom_range(0, 4) == 0) begin
            gl.push_back($urandom_range(1, 10));
            pl.push_back(1);
          end
          gl.push_back($urandom_range(1, 20));
        end
      end
    end else begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        pl.push_back($urandom_range(1, 30));
        a = $urandom_range(1, 20);
        if (i < n - 1) gl.push_back(a);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_code"}, morse_code, 0);
    chk({tag, "_len"}, morse_len, 0);
    chk({tag, "_char"}, char_code, 63);
    chk({tag, "_valid"}, char_valid, 0);
    chk({tag, "_err"}, char_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int e0;
    #1 rst = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    hold(1'b0, 3);

    pl = '{5, 20};            gl = '{8};           run_char();  // A
    pl = '{3};                gl = '{};            run_char();  // E
    pl = '{5, 5, 5, 5, 5};    gl = '{8, 8, 8, 8};  run_char();  // 5
    pl = '{20, 20, 20, 20, 20}; gl = '{8, 8, 8, 8}; run_char(); // 0
    pl = '{5, 1, 5};          gl = '{4, 4};        run_char();  // I despite glitch
    pl = '{1};                gl = '{};            run_char();  // isolated glitch
    pl = '{5, 5, 5, 5, 5, 5}; gl = '{8, 8, 8, 8, 8}; run_char(); // overflow
    pl = '{5, 5, 20, 20};     gl = '{8, 8, 8};     run_char();  // no match
    pl = '{2, 11};            gl = '{6};           run_char();  // boundary dot/dash
    pl = '{10};               gl = '{};            run_char();  // longest dot
    pl = '{200};              gl = '{};            run_char();  // long dash

    hold(1'b1, 8);
    #2 rst = 1'b0;
    #1 check_reset_outputs("mid_reset");
    key_in = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    last_code = 6'd63;
    e0 = ev_n;
    hold(1'b0, LETTER_GAP + 10);
    chk("no_emit_after_reset", ev_n - e0, 0);
    pl = '{20}; gl = '{}; run_char();  // T

    key_in = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    e0 = ev_n;
    hold(1'b1, 15);
    key_in   = 1'b0;
    fall_cyc = cyc;
    pl = '{15}; gl = '{};
    evaluate(e0);

    for (int t = 0; t < 40; t++) begin
      gen_random();
      run_char();
    end

    chk("valid_err_exclusive", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
